// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a valid/ready FIFO; runtime divisor and parity, 1 or 2 stop bits.
// Optional line-break input enabled by defining UART_TX_BREAK_EN.
module uart_tx_fifo #(
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 8,
   parameter int STOP_BITS  = 1,
   parameter int DIV_W      = 16
) (
   input  logic                        clock,
   input  logic                        resetb,
   input  logic [DATA_BITS-1:0]        tx_data,
   input  logic                        tx_valid,
   output logic                        tx_ready,
   input  logic [DIV_W-1:0]            baud_div,
   input  logic                        parity_en,
   input  logic                        parity_odd,
`ifdef UART_TX_BREAK_EN
   input  logic                        break_req,
`endif
   output logic                        ser_tx,
   output logic                        tx_busy,
   output logic                        tx_done,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int BW = $clog2(DATA_BITS);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
   localparam logic LAST_STOP = (STOP_BITS == 2);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] START  = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
   localparam logic [2:0] PARITY = 3'd3;
   localparam logic [2:0] STOP   = 3'd4;
`ifdef UART_TX_BREAK_EN
   localparam logic [2:0] BREAK  = 3'd5;
   localparam logic [2:0] GAP    = 3'd6;
`endif

   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [AW:0]          wr_ptr;
   logic [AW:0]          rd_ptr;
   logic                 full;
   logic                 empty;
   logic                 push;
   logic                 pop;
   logic                 brk;
   logic [DATA_BITS-1:0] head;

   logic [2:0]           state;
   logic [DIV_W-1:0]     div_eff;
   logic [DIV_W-1:0]     div_q;
   logic [DIV_W-1:0]     cnt;
   logic                 tick;
   logic [DATA_BITS-1:0] shreg;
   logic [BW-1:0]        bit_cnt;
   logic                 stop_cnt;
   logic                 par_en_q;
   logic                 par_bit;
   logic                 ser_q;
   logic                 done_q;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign push  = tx_valid & ~full;
`ifdef UART_TX_BREAK_EN
   assign brk   = break_req;
`else
   assign brk   = 1'b0;
`endif
   assign pop   = (state == IDLE) & ~empty & ~brk;
   assign head  = mem[rd_ptr[AW-1:0]];

   assign div_eff = (baud_div < DIV_W'(2)) ? DIV_W'(1) : baud_div;
   assign tick    = (cnt == '0);

   always_ff @(posedge clock) begin
      if (push) begin
         mem[wr_ptr[AW-1:0]] <= tx_data;
      end
   end

   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + (AW+1)'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + (AW+1)'(1);
         end
      end
   end

   // Divisor and parity are captured at pop so mid-frame changes only affect later frames.
   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         state    <= IDLE;
         ser_q    <= 1'b1;
         done_q   <= 1'b0;
         cnt      <= '0;
         div_q    <= DIV_W'(1);
         shreg    <= '0;
         bit_cnt  <= '0;
         stop_cnt <= 1'b0;
         par_en_q <= 1'b0;
         par_bit  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (pop) begin
                  shreg    <= head;
                  div_q    <= div_eff;
                  cnt      <= div_eff - DIV_W'(1);
                  par_en_q <= parity_en;
                  par_bit  <= (^head) ^ parity_odd;
                  ser_q    <= 1'b0;
                  state    <= START;
               end
`ifdef UART_TX_BREAK_EN
               else if (break_req) begin
                  ser_q <= 1'b0;
                  state <= BREAK;
               end
            end
            BREAK: begin
               if (!break_req) begin
                  ser_q <= 1'b1;
                  cnt   <= div_eff - DIV_W'(1);
                  state <= GAP;
               end
`endif
            end
            default: begin
               if (!tick) begin
                  cnt <= cnt - DIV_W'(1);
               end else begin
                  cnt <= div_q - DIV_W'(1);
                  case (state)
                     START: begin
                        ser_q   <= shreg[0];
                        bit_cnt <= '0;
                        state   <= DATA;
                     end
                     DATA: begin
                        if (bit_cnt == LAST_BIT) begin
                           if (par_en_q) begin
                              ser_q <= par_bit;
                              state <= PARITY;
                           end else begin
                              ser_q    <= 1'b1;
                              stop_cnt <= 1'b0;
                              state    <= STOP;
                           end
                        end else begin
                           ser_q   <= shreg[1];
                           shreg   <= shreg >> 1;
                           bit_cnt <= bit_cnt + BW'(1);
                        end
                     end
                     PARITY: begin
                        ser_q    <= 1'b1;
                        stop_cnt <= 1'b0;
                        state    <= STOP;
                     end
                     STOP: begin
                        if (stop_cnt == LAST_STOP) begin
                           done_q <= 1'b1;
                           state  <= IDLE;
                        end else begin
                           stop_cnt <= 1'b1;
                        end
                     end
                     default: begin
                        ser_q <= 1'b1;
                        state <= IDLE;
                     end
                  endcase
               end
            end
         endcase
      end
   end

   assign ser_tx     = ser_q;
   assign tx_done    = done_q;
   assign tx_ready   = ~full;
   assign fifo_level = wr_ptr - rd_ptr;
   assign tx_busy    = (state != IDLE) | (fifo_level != '0);

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Parametrised, synthesizable UART transmitter with an input FIFO; it succeeds the single-byte, testbench-only transmit model used on the user-project UART pins.
- Adds variable data width, runtime baud divisor, runtime parity, 1/2 stop bits and a FIFO level report.
- Sits in the user project, drives the serial line toward the management core's UART RX (mprj_io[5]).
- Feeds a word-level valid/ready producer (Wishbone slave or firmware-driven logic).

Parameters:
- DATA_BITS, 8, payload bits per frame; legal 5..8.
- FIFO_DEPTH, 8, FIFO entries; power of 2, >=2.
- STOP_BITS, 1, stop bits per frame; legal 1 or 2.
- DIV_W, 16, width of the baud divisor input.

Ports:
- clock  in  1  system clock.
- resetb  in  1  asynchronous active-low reset.
- tx_data  in  DATA_BITS  word to enqueue.
- tx_valid  in  1  producer has a word.
- tx_ready  out  1  FIFO can accept (= !full).
- baud_div  in  DIV_W  clock cycles per bit; 0 or 1 treated as 1.
- parity_en  in  1  insert a parity bit.
- parity_odd  in  1  1 = odd parity, 0 = even parity.
- ser_tx  out  1  serial line, idle high.
- tx_busy  out  1  frame in progress or FIFO non-empty.
- tx_done  out  1  one-cycle pulse when a frame's last stop bit ends.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  entries currently queued.

Behaviour:
- Reset is asynchronous assert, synchronous deassert handled upstream.
- Reset values: ser_tx=1, tx_ready=1, tx_busy=0, tx_done=0, fifo_level=0; FIFO pointers cleared; FSM in IDLE.
- Push: on a clock edge with tx_valid & tx_ready. When full, tx_ready=0 and the word is not taken, even if a pop occurs the same cycle.
- Simultaneous push and pop: fifo_level is unchanged.
- Pointers wrap modulo FIFO_DEPTH. An extra MSB distinguishes full from empty.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: if the FIFO is non-empty, pop the head into the shift register and go to START.
  - Also latch baud_div, parity_en and parity_odd; runtime changes take effect only at the next frame.
  - ser_tx stays 1.
- Latency: a word pushed into an empty FIFO while IDLE is registered at edge N. It is popped at edge N+1. ser_tx goes 0 after edge N+1.
- Every bit lasts exactly the latched divisor number of cycles. A down-counter reloads at each bit boundary.
- START: ser_tx=0 for one bit time, then DATA.
- DATA: DATA_BITS bits, LSB first; a bit counter counts 0..DATA_BITS-1. Then go to PARITY if parity is enabled, else STOP.
- Parity bit:
  - Even parity: XOR of the data bits, so the total number of ones including parity is even.
  - Odd parity: the inverse.
- STOP: ser_tx=1 for STOP_BITS bit times.
  - At the final cycle of the last stop bit, tx_done pulses for 1 cycle.
  - Next state is IDLE. If the FIFO is non-empty the next pop happens on the next edge, so the inter-frame gap is 0 idle bits and the start bit immediately follows the stop bit(s) after one cycle.
- Frame length in cycles: div × (1 + DATA_BITS + parity_en + STOP_BITS), plus 1 pop cycle per frame.
- tx_busy = (state != IDLE) | (fifo_level != 0).
- Reset mid-frame: ser_tx returns to 1 immediately and asynchronously; queued data is discarded; no tx_done pulse.
- ser_tx is driven from a flop (no combinational glitches).

Optional Feature:
- Macro: UART_TX_BREAK_EN.
- With the macro defined:
  - Extra input port break_req (1 bit).
  - When asserted in IDLE, ser_tx is held 0 for as long as break_req stays high. The FIFO does not pop during the break; tx_busy=1.
  - On deassertion, ser_tx returns to 1 and one full bit time of idle high precedes the next start bit.
  - break_req asserted mid-frame is ignored until the frame completes.
- Without the macro: no port; the line is never held low outside start/data bits.

Test Plan:
1. Single 8-bit frame: baud_div=4, no parity, STOP_BITS=1, push 0x3D (61). Required:
   - ser_tx bit sequence 0,1,0,1,1,1,1,0,0,1, each bit 4 cycles.
   - tx_done pulses after 40 cycles of frame.
   - tx_busy falls the same cycle tx_done pulses.
2. Parity: push 0x3D with parity_en=1.
   - parity_odd=0: parity bit =1.
   - parity_odd=1: parity bit =0.
   - Frame is 44 cycles at div=4.
3. FIFO full/back-to-back: push 0x3D, 0x0F, 0x12, 0x37 and more until tx_ready=0 with DEPTH=8 (9 accepted total: 1 popped plus 8 queued). Required:
   - The next push is refused.
   - Frames emerge in order, back-to-back, with tx_done pulsing 9 times.
   - fifo_level reaches 0.
4. Runtime divisor change: change baud_div from 4 to 8 mid-frame. The current frame keeps 4 cycles/bit; the next frame uses 8.
5. Reset mid-frame: assert resetb=0 during DATA bit 3. Required:
   - ser_tx=1 immediately; fifo_level=0.
   - After release, no residual frame is transmitted.
6. DATA_BITS=5, STOP_BITS=2, div=1: push 0x15. Required: ser_tx = 0,1,0,1,0,1,1,1, one cycle each.
   - With UART_TX_BREAK_EN: break_req held 20 cycles gives ser_tx=0 for 20 cycles, then ≥1 idle bit before the next queued frame.
